// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the sequential IEEE-754 single-precision
// adder/subtractor: field widths, format constants and the controller
// state encoding.
// ---------------------------------------------------------------------------
package fp_pkg;

   localparam int          EXP_W     = 8;
   localparam int          MAN_W     = 23;
   localparam int          BIAS      = 127;
   localparam logic [31:0] QNAN      = 32'h7FC00000;
   localparam int          EXP_MAX   = 255;
   // Beyond 24 shifts the smaller mantissa is entirely gone, so the
   // alignment count is clamped here.
   localparam int          ALIGN_SAT = 24;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMP   = 3'd1,
      ALIGN = 3'd2,
      ADD   = 3'd3,
      NORM  = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/fp_addsub_seq_if.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq_if
// Operand/result handshake bundle for fp_addsub_seq.
//   in_valid/in_ready : operand transfer (a, b, op)
//   out_valid/out_ready : result transfer (result)
// master = producer/consumer side, slave = the arithmetic unit.
// ---------------------------------------------------------------------------
interface fp_addsub_seq_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);

   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result
   );

endinterface

// File: rtl/exp_comparator.sv
// ---------------------------------------------------------------------------
// exp_comparator
// Combinational exponent comparison.
//   ea, eb  : biased exponents
//   diff    : |ea - eb|
//   bigger  : 0 = equal, 1 = A larger, 2 = B larger
// ---------------------------------------------------------------------------
module exp_comparator #(
   parameter int EXP_W = 8
) (
   input  logic [EXP_W-1:0] ea,
   input  logic [EXP_W-1:0] eb,
   output logic [EXP_W-1:0] diff,
   output logic [1:0]       bigger
);

   logic signed [EXP_W:0] d;

   always_comb begin
      // One extra bit so the sign of the difference is never lost.
      d = $signed({1'b0, ea}) - $signed({1'b0, eb});
      if (d < 0) begin
         diff   = EXP_W'(-d);
         bigger = 2'd2;
      end else if (d == 0) begin
         diff   = '0;
         bigger = 2'd0;
      end else begin
         diff   = d[EXP_W-1:0];
         bigger = 2'd1;
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq
// Multi-cycle IEEE-754 adder/subtractor, one operation in flight.
// Alignment and normalisation shift one bit per cycle; denormal inputs
// are flushed to zero and shifted-out bits are truncated.
//   clk, rst : clock, synchronous active-high reset
//   io       : slave side of fp_addsub_seq_if (operands in, result out)
//   busy     : high whenever the controller is not in IDLE
// ---------------------------------------------------------------------------
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic           clk,
   input  logic           rst,
   fp_addsub_seq_if.slave io,
   output logic           busy
);

   import fp_pkg::*;

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 1;
   localparam int CW = $clog2(ALIGN_SAT + 1);
   localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic [W-1:0]   QNAN_V = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // Packs a result, saturating to signed Inf on exponent overflow and to
   // signed zero on exponent underflow.
   function automatic logic [W-1:0] pack(input logic s, input logic [EXP_W:0] e,
                                         input logic [MW:0] m);
      if (e >= EMAX)
         return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (e == '0)
         return {s, {(W-1){1'b0}}};
      else
         return {s, e[EXP_W-1:0], m[MAN_W-1:0]};
   endfunction

   state_t          state, state_nxt;
   logic [W-1:0]    opa, opb;
   logic [EXP_W:0]  exp_r;
   logic [MW-1:0]   man_big, man_sml;
   logic            sgn_big, sgn_sml;
   logic [CW-1:0]   cnt;
   logic [MW:0]     man_r;
   logic            sgn_r;
   logic [W-1:0]    res_r;

   // Operand fields; a zero exponent drops the hidden bit and the fraction.
   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic [MW-1:0]    ma, mb;
   assign sa = opa[W-1];
   assign sb = opb[W-1];
   assign ea = opa[W-2 -: EXP_W];
   assign eb = opb[W-2 -: EXP_W];
   assign fa = opa[MAN_W-1:0];
   assign fb = opb[MAN_W-1:0];
   assign ma = (ea != '0) ? {1'b1, fa} : '0;
   assign mb = (eb != '0) ? {1'b1, fb} : '0;

   logic [EXP_W-1:0] ediff;
   logic [1:0]       ebig;

   exp_comparator #(.EXP_W(EXP_W)) u_exp_cmp (
      .ea     (ea),
      .eb     (eb),
      .diff   (ediff),
      .bigger (ebig)
   );

   logic          special;
   logic [W-1:0]  spec_res;
   logic [CW-1:0] cnt_load;
   logic [MW:0]   add_man;
   logic          add_sgn, add_zero, add_direct;
   logic [MW:0]   n_man;
   logic [EXP_W:0] n_exp;
   logic          n_done;

   always_comb begin
      // CMP: special operands and alignment distance
      special  = (&ea) | (&eb);
      if (((&ea) && fa != '0) || ((&eb) && fb != '0) ||
          ((&ea) && (&eb) && sa != sb))
         spec_res = QNAN_V;
      else if (&ea)
         spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
         spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      cnt_load = (ediff >= EXP_W'(ALIGN_SAT)) ? CW'(ALIGN_SAT) : CW'(ediff);

      // ADD: magnitude add or subtract; the compare also covers equal exponents
      if (sgn_big == sgn_sml) begin
         add_man = {1'b0, man_big} + {1'b0, man_sml};
         add_sgn = sgn_big;
      end else if (man_big >= man_sml) begin
         add_man = {1'b0, man_big} - {1'b0, man_sml};
         add_sgn = sgn_big;
      end else begin
         add_man = {1'b0, man_sml} - {1'b0, man_big};
         add_sgn = sgn_sml;
      end
      add_zero   = (add_man == '0);
      add_direct = !add_man[MW] && add_man[MW-1];

      // NORM: one shift per cycle
      n_man  = man_r;
      n_exp  = exp_r;
      n_done = 1'b0;
      if (man_r[MW]) begin
         n_man  = man_r >> 1;
         n_exp  = exp_r + 1'b1;
         n_done = 1'b1;
      end else if (man_r[MW-1]) begin
         n_done = 1'b1;
      end else begin
         n_man  = man_r << 1;
         n_exp  = exp_r - 1'b1;
         n_done = (n_exp == '0) || n_man[MW-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io.in_valid) state_nxt = CMP;
         CMP:     if (special)            state_nxt = DONE;
                  else if (ediff != '0)   state_nxt = ALIGN;
                  else                    state_nxt = ADD;
         ALIGN:   if (cnt <= CW'(1)) state_nxt = ADD;
         ADD:     if (add_zero || add_direct) state_nxt = DONE;
                  else                        state_nxt = NORM;
         NORM:    if (n_done) state_nxt = DONE;
         DONE:    if (io.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      io.in_ready  = (state == IDLE);
      io.out_valid = (state == DONE);
      busy         = (state != IDLE);
      io.result    = res_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa     <= '0;
         opb     <= '0;
         exp_r   <= '0;
         man_big <= '0;
         man_sml <= '0;
         sgn_big <= 1'b0;
         sgn_sml <= 1'b0;
         cnt     <= '0;
         man_r   <= '0;
         sgn_r   <= 1'b0;
         res_r   <= '0;
      end else begin
         case (state)
            // IDLE: capture operands, folding op into the sign of B
            IDLE: if (io.in_valid) begin
               opa <= io.a;
               opb <= {io.b[W-1] ^ io.op, io.b[W-2:0]};
            end
            // CMP: order operands by exponent
            CMP: begin
               if (special) begin
                  res_r <= spec_res;
               end else if (ebig == 2'd2) begin
                  exp_r   <= {1'b0, eb};
                  man_big <= mb;
                  sgn_big <= sb;
                  man_sml <= ma;
                  sgn_sml <= sa;
               end else begin
                  exp_r   <= {1'b0, ea};
                  man_big <= ma;
                  sgn_big <= sa;
                  man_sml <= mb;
                  sgn_sml <= sb;
               end
               cnt <= cnt_load;
            end
            // ALIGN: truncating right shift of the smaller mantissa
            ALIGN: begin
               man_sml <= man_sml >> 1;
               cnt     <= cnt - 1'b1;
            end
            // ADD
            ADD: begin
               man_r <= add_man;
               sgn_r <= add_sgn;
               if (add_zero)
                  res_r <= '0;
               else if (add_direct)
                  res_r <= pack(add_sgn, exp_r, add_man);
            end
            // NORM
            NORM: begin
               man_r <= n_man;
               exp_r <= n_exp;
               if (n_done) res_r <= pack(sgn_r, n_exp, n_man);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_seq
// Directed vectors with hand-computed results and accept-to-valid latency
// for fp_addsub_seq.
// ---------------------------------------------------------------------------
module tb_fp_addsub_seq;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   lat;

   fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk  (clk),
      .rst  (rst),
      .io   (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, want);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
      bus.a        = a;
      bus.b        = b;
      bus.op       = op;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Latency counts the accept cycle as 1; bounded so a stuck DUT still ends.
   task automatic wait_valid(output int l);
      l = 1;
      while (!bus.out_valid && l < 100) begin
         tick();
         l++;
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic [31:0] want, input int want_lat);
      int l;
      chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
      send(a, b, op);
      wait_valid(l);
      chk({tag, "_res"}, bus.result, want);
      chk({tag, "_lat"}, l, want_lat);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_vld0"}, {31'd0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy",      {31'd0, busy},          32'd0);
      chk("rst_result",    bus.result,             32'h0);
      rst = 1'b0;
      tick();

      run("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);
      run("one_minus_3q",  32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 6);
      run("exact_cancel",  32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3);
      run("align_sat",     32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 27);
      run("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4);
      run("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2);
      run("nan_in",        32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 2);
      run("one_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2);
      run("denorm_flush",  32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 27);
      run("neg_result",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 5);
      run("eq_exp_swap",   32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4);

      // Result held while the consumer stalls; new operands are ignored.
      send(32'h3F800000, 32'h3F800000, 1'b0);
      wait_valid(lat);
      chk("hold_lat", lat, 4);
      bus.a        = 32'h40400000;
      bus.b        = 32'h40400000;
      bus.op       = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_result",   bus.result,             32'h40000000);
         chk("hold_out_vld",  {31'd0, bus.out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, bus.in_ready},  32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("rel_out_vld",  {31'd0, bus.out_valid}, 32'd0);
      chk("rel_in_ready", {31'd0, bus.in_ready},  32'd1);
      chk("rel_result",   bus.result,             32'h40000000);

      // Reset in the middle of a long alignment.
      send(32'h3F800000, 32'h30800000, 1'b0);
      repeat (4) tick();
      chk("mid_busy",    {31'd0, busy},          32'd1);
      chk("mid_out_vld", {31'd0, bus.out_valid}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_in_ready", {31'd0, bus.in_ready},  32'd1);
      chk("mrst_out_vld",  {31'd0, bus.out_valid}, 32'd0);
      chk("mrst_busy",     {31'd0, busy},          32'd0);
      chk("mrst_result",   bus.result,             32'h0);
      run("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
